reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_flag_reg.sv | 22 ++
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default widths, register count,
// flag bit positions inside FLAGS and the write-counter ceiling.
package reg_file_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  localparam int FLAGS_W = 4;
  localparam int FLAG_C  = 3;
  localparam int FLAG_V  = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_Z  = 0;

  localparam int          WR_CNT_W   = 8;
  localparam logic [7:0]  WR_CNT_MAX = 8'd255;

endpackage : reg_file_pkg

// File: rtl/reg_file_flag_reg.sv
// Condition-code register: captures the packed ALU flags when enabled,
// otherwise holds. Cleared by the synchronous active-low reset.
module flag_reg
  import reg_file_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [FLAGS_W-1:0] flags
);

  // Load the new flags on enable; reset wins over a simultaneous enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (en) begin
      flags <= flags_in;
    end
  end

endmodule : flag_reg

// File: rtl/reg_file.sv
// Two-read / one-write register file feeding an ALU. R0 is hard-wired to
// zero, reads are combinational with no write-to-read bypass, and a
// saturating counter tracks the number of writes that actually landed.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   RA_ADDR,
  input  logic [ADDR_W-1:0]   RB_ADDR,
  output logic [DATA_W-1:0]   A,
  output logic [DATA_W-1:0]   B,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   W_ADDR,
  input  logic [DATA_W-1:0]   W_DATA,
  input  logic                FLAG_WE,
  input  logic                C_IN,
  input  logic                V_IN,
  input  logic                N_IN,
  input  logic                Z_IN,
  output logic [FLAGS_W-1:0]  FLAGS,
  output logic [WR_CNT_W-1:0] WR_CNT
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]  regs [NREGS];
  logic               wr_accept;
  logic [FLAGS_W-1:0] flags_in;

  // A write only counts when it targets a real register; R0 writes vanish.
  assign wr_accept = WE && (W_ADDR != '0);

  // Register array update; every entry clears on reset, including R0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_accept) begin
      regs[W_ADDR] <= W_DATA;
    end
  end

  // Zero-latency read ports; address 0 is forced to zero regardless of storage.
  always_comb begin
    A = (RA_ADDR == '0) ? '0 : regs[RA_ADDR];
    B = (RB_ADDR == '0) ? '0 : regs[RB_ADDR];
  end

  // Saturating count of accepted writes; sticks at the ceiling instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      WR_CNT <= '0;
    end else if (wr_accept && (WR_CNT != WR_CNT_MAX)) begin
      WR_CNT <= WR_CNT + 8'd1;
    end
  end

  // Pack the individual ALU flags into their FLAGS bit positions.
  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_C] = C_IN;
    flags_in[FLAG_V] = V_IN;
    flags_in[FLAG_N] = N_IN;
    flags_in[FLAG_Z] = Z_IN;
  end

  flag_reg u_flag_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (FLAG_WE),
    .flags_in (flags_in),
    .flags    (FLAGS)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file. The stimulus thread drives one cycle at a
// time and queues the values it expects to see in that cycle; a monitor on
// the falling edge drains the queue and compares against the DUT outputs.
module tb_reg_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam int K_A   = 0;
  localparam int K_B   = 1;
  localparam int K_FLG = 2;
  localparam int K_CNT = 3;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              flag_we;
  logic              c_in;
  logic              v_in;
  logic              n_in;
  logic              z_in;
  logic [3:0]        flags;
  logic [7:0]        wr_cnt;

  int total;
  int bad;

  int          q_kind [$];
  logic [15:0] q_exp  [$];
  string       q_name [$];

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RA_ADDR (ra_addr),
    .RB_ADDR (rb_addr),
    .A       (a),
    .B       (b),
    .WE      (we),
    .W_ADDR  (w_addr),
    .W_DATA  (w_data),
    .FLAG_WE (flag_we),
    .C_IN    (c_in),
    .V_IN    (v_in),
    .N_IN    (n_in),
    .Z_IN    (z_in),
    .FLAGS   (flags),
    .WR_CNT  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  // Advance to just after the next rising edge so new inputs settle before the check.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we      = 1'b0;
    flag_we = 1'b0;
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q_kind.size() > 0) begin
      int          k;
      logic [15:0] e;
      logic [15:0] act;
      string       nm;
      k   = q_kind.pop_front();
      e   = q_exp.pop_front();
      nm  = q_name.pop_front();
      case (k)
        K_A:     act = {8'h00, a};
        K_B:     act = {8'h00, b};
        K_FLG:   act = {12'h000, flags};
        default: act = {8'h00, wr_cnt};
      endcase
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, e);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;

    // Reset with a write and flag update pending in the same cycle.
    rst_n   = 1'b0;
    ra_addr = '0;
    rb_addr = '0;
    we      = 1'b1;
    w_addr  = 3'd3;
    w_data  = 8'hAA;
    flag_we = 1'b1;
    {c_in, v_in, n_in, z_in} = 4'b1111;
    cyc();

    rst_n   = 1'b1;
    idle();
    ra_addr = 3'd3;
    rb_addr = 3'd3;
    expect_val(K_A,   16'h00, "rst_r3_a");
    expect_val(K_FLG, 16'h0,  "rst_flags");
    expect_val(K_CNT, 16'h00, "rst_wrcnt");
    cyc();

    // Every address reads zero after reset.
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i);
      rb_addr = 3'(7 - i);
      expect_val(K_A, 16'h00, "rst_sweep_a");
      expect_val(K_B, 16'h00, "rst_sweep_b");
      cyc();
    end

    // Write R2 with same-address reads: old value now, new value next cycle.
    we      = 1'b1;
    w_addr  = 3'd2;
    w_data  = 8'h5C;
    ra_addr = 3'd2;
    rb_addr = 3'd2;
    expect_val(K_A, 16'h00, "no_bypass_a");
    expect_val(K_B, 16'h00, "no_bypass_b");
    cyc();
    idle();
    expect_val(K_A,   16'h5C, "r2_read_a");
    expect_val(K_B,   16'h5C, "r2_read_b");
    expect_val(K_CNT, 16'h01, "cnt_after_r2");
    cyc();

    // Write to R0 is discarded and not counted.
    we      = 1'b1;
    w_addr  = 3'd0;
    w_data  = 8'hFF;
    ra_addr = 3'd0;
    expect_val(K_A, 16'h00, "r0_write_cycle");
    cyc();
    idle();
    expect_val(K_A,   16'h00, "r0_reads_zero");
    expect_val(K_CNT, 16'h01, "r0_not_counted");
    cyc();

    // Flag load then hold with all inputs high.
    flag_we = 1'b1;
    {c_in, v_in, n_in, z_in} = 4'b1010;
    cyc();
    flag_we = 1'b0;
    {c_in, v_in, n_in, z_in} = 4'b1111;
    expect_val(K_FLG, 16'hA, "flags_load");
    cyc();
    expect_val(K_FLG, 16'hA, "flags_hold");
    cyc();

    // Simultaneous register write and flag update.
    we      = 1'b1;
    w_addr  = 3'd5;
    w_data  = 8'h33;
    flag_we = 1'b1;
    {c_in, v_in, n_in, z_in} = 4'b0001;
    cyc();
    idle();
    ra_addr = 3'd5;
    expect_val(K_A,   16'h33, "dual_we_r5");
    expect_val(K_FLG, 16'h1,  "dual_we_flags");
    expect_val(K_CNT, 16'h02, "dual_we_cnt");
    cyc();

    // Mid-program reset discards the write of that cycle and clears everything.
    rst_n   = 1'b0;
    we      = 1'b1;
    w_addr  = 3'd4;
    w_data  = 8'h77;
    flag_we = 1'b1;
    {c_in, v_in, n_in, z_in} = 4'b1111;
    cyc();
    rst_n   = 1'b1;
    idle();
    ra_addr = 3'd4;
    rb_addr = 3'd2;
    expect_val(K_A,   16'h00, "midrst_r4");
    expect_val(K_B,   16'h00, "midrst_r2");
    expect_val(K_FLG, 16'h0,  "midrst_flags");
    expect_val(K_CNT, 16'h00, "midrst_cnt");
    cyc();

    // ALU loop: 0x7F + 0x01 = 0x80, overflow into negative, no carry, nonzero.
    we     = 1'b1;
    w_addr = 3'd1;
    w_data = 8'h7F;
    cyc();
    w_addr = 3'd2;
    w_data = 8'h01;
    cyc();
    ra_addr = 3'd1;
    rb_addr = 3'd2;
    w_addr  = 3'd3;
    w_data  = 8'h80;
    flag_we = 1'b1;
    {c_in, v_in, n_in, z_in} = 4'b0110;
    expect_val(K_A, 16'h7F, "alu_opa");
    expect_val(K_B, 16'h01, "alu_opb");
    cyc();
    idle();
    ra_addr = 3'd3;
    expect_val(K_A,   16'h80, "alu_r3");
    expect_val(K_FLG, 16'h6,  "alu_flags");
    expect_val(K_CNT, 16'h03, "alu_cnt");
    cyc();

    // 300 writes to R1 starting from a count of 3: saturates after 252 of them.
    for (int i = 0; i < 300; i++) begin
      we     = 1'b1;
      w_addr = 3'd1;
      w_data = 8'(i);
      if (i >= 250 && i <= 254) begin
        expect_val(K_CNT, (3 + i > 255) ? 16'd255 : 16'(3 + i), "cnt_ramp");
      end
      cyc();
    end
    idle();
    ra_addr = 3'd1;
    expect_val(K_CNT, 16'hFF, "cnt_saturated");
    expect_val(K_A,   16'h2B, "r1_last_data");
    cyc();

    @(negedge clk);
    #1;
    if (q_kind.size() != 0) begin
      bad += q_kind.size();
      $display("FAIL expired_wait: %0d expectation(s) never checked", q_kind.size());
    end
    if (bad != 0 || total < 12) begin
      $display("FAIL summary: total=%0d bad=%0d", total, bad);
    end else begin
      $display("PASS");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file
